// File: rtl/arcade_trackball_emu.sv
// arcade_trackball_emu: held direction controls to accelerating trackball steps, quadrature and position
// Ports:
//   clk_i, res_n_i   system clock, asynchronous active-low reset
//   ce_i             clock enable; state advances only when high
//   enable_i         low forces every axis to behave as released
//   neg_i, pos_i     per-axis decrement / increment controls
//   step_o           one-clk pulse per step
//   dir_o            1 = last step was positive
//   quad_a_o/_b_o    quadrature phases
//   count_o          wrapping position counters, axis k at [k*CNT_W +: CNT_W]
module arcade_trackball_emu #(
    parameter int NUM_AXES    = 2,
    parameter int CNT_W       = 4,
    parameter int DIV_W       = 16,
    parameter int BASE_DIV    = 3000,
    parameter int MIN_DIV     = 375,
    parameter int ACCEL_STEP  = 250,
    parameter int ACCEL_EVERY = 8
) (
    input  logic                      clk_i,
    input  logic                      res_n_i,
    input  logic                      ce_i,
    input  logic                      enable_i,
    input  logic [NUM_AXES-1:0]       neg_i,
    input  logic [NUM_AXES-1:0]       pos_i,
    output logic [NUM_AXES-1:0]       step_o,
    output logic [NUM_AXES-1:0]       dir_o,
    output logic [NUM_AXES-1:0]       quad_a_o,
    output logic [NUM_AXES-1:0]       quad_b_o,
    output logic [NUM_AXES*CNT_W-1:0] count_o
);
    localparam int ACC_W = $clog2(ACCEL_EVERY + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    genvar k;
    generate
        for (k = 0; k < NUM_AXES; k++) begin : g_axis
            logic [0:0]       st;
            logic             stp, dr, req, fresh, hit, go, sdir, acc_wrap;
            logic [1:0]       q;
            logic [CNT_W-1:0] cnt;
            logic [DIV_W-1:0] div, tmr, ndiv;
            logic [ACC_W-1:0] acc;
            always_comb begin
                req      = enable_i & (pos_i[k] ^ neg_i[k]);
                // a press from idle and a reversal both restart the axis
                fresh    = req & ((st == IDLE) | (pos_i[k] != dr));
                hit      = req & ~fresh & (tmr == div - DIV_W'(1));
                go       = fresh | hit;
                sdir     = fresh ? pos_i[k] : dr;
                acc_wrap = (acc == ACC_W'(ACCEL_EVERY - 1));
                // compared one bit wider so the shrink can never wrap below MIN_DIV
                ndiv     = ({1'b0, div} >= (DIV_W+1)'(MIN_DIV + ACCEL_STEP)) ?
                           div - DIV_W'(ACCEL_STEP) : DIV_W'(MIN_DIV);
            end
            always_ff @(posedge clk_i or negedge res_n_i) begin
                if (!res_n_i) begin
                    st  <= IDLE;
                    stp <= 1'b0;
                    dr  <= 1'b0;
                    q   <= 2'b00;
                    cnt <= '0;
                    div <= DIV_W'(BASE_DIV);
                    tmr <= '0;
                    acc <= '0;
                end else begin
                    stp <= ce_i & go;
                    if (ce_i) begin
                        if (go) begin
                            dr  <= sdir;
                            cnt <= sdir ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
                            // Gray sequence 00->01->11->10 forward, reversed backward
                            q   <= sdir ? {q[0], ~q[1]} : {~q[0], q[1]};
                        end
                        if (fresh) begin
                            st  <= RUN;
                            div <= DIV_W'(BASE_DIV);
                            tmr <= '0;
                            acc <= ACC_W'(1);
                        end else if (!req) begin
                            st  <= IDLE;
                            div <= DIV_W'(BASE_DIV);
                            tmr <= '0;
                            acc <= '0;
                        end else if (hit) begin
                            tmr <= '0;
                            acc <= acc_wrap ? '0 : acc + ACC_W'(1);
                            if (acc_wrap) div <= ndiv;
                        end else begin
                            tmr <= tmr + DIV_W'(1);
                        end
                    end
                end
            end
            assign step_o[k]                  = stp;
            assign dir_o[k]                   = dr;
            assign quad_a_o[k]                = q[1];
            assign quad_b_o[k]                = q[0];
            assign count_o[k*CNT_W +: CNT_W] = cnt;
        end
    endgenerate
endmodule

// File: tb/tb_arcade_trackball_emu.sv
// tb_arcade_trackball_emu: directed checks of step timing, acceleration, wrap, reversal, ce, enable and reset
module tb_arcade_trackball_emu;
    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       ce = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] neg = 2'b00;
    logic [1:0] pos = 2'b00;
    logic [1:0] step, dir, qa, qb;
    logic [7:0] count;
    logic       tog = 1'b0;
    int         total = 0;
    int         bad = 0;

    arcade_trackball_emu #(
        .NUM_AXES(2), .CNT_W(4), .DIV_W(16), .BASE_DIV(4),
        .MIN_DIV(2), .ACCEL_STEP(1), .ACCEL_EVERY(2)
    ) dut (
        .clk_i(clk), .res_n_i(res_n), .ce_i(ce), .enable_i(enable),
        .neg_i(neg), .pos_i(pos), .step_o(step), .dir_o(dir),
        .quad_a_o(qa), .quad_b_o(qb), .count_o(count)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] gray(input logic [3:0] c);
        return {c[1], c[1] ^ c[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (tog) ce = ~ce;
        end
    endtask

    task automatic pulses(input int ax, input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (step[ax]) c++;
        end
    endtask

    task automatic do_step(input int ax, input int gap, input logic [3:0] cnt, input string tag);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!step[ax] && n < 64);
        chk({tag, "_gap"}, n, gap);
        chk({tag, "_cnt"}, count[ax*4 +: 4], cnt);
        chk({tag, "_quad"}, {qa[ax], qb[ax]}, gray(cnt));
    endtask

    initial begin
        int c;
        int gaps[6] = '{4, 3, 3, 2, 2, 2};
        tick(3);
        chk("rst_out", {step, dir, qa, qb, count}, 0);
        res_n = 1'b1;
        pulses(0, 20, c);
        chk("idle_p0", c, 0);
        chk("idle_p1_out", {step, dir, qa, qb, count}, 0);

        pos[0] = 1'b1;
        do_step(0, 1, 4'd1, "p1");
        for (int i = 2; i <= 16; i++)
            do_step(0, i <= 7 ? gaps[i-2] : 2, 4'(i), $sformatf("p%0d", i));
        chk("p_dir", dir[0], 1'b1);
        chk("p_ax1", {step[1], dir[1], qa[1], qb[1], count[7:4]}, 0);

        pos[0] = 1'b0;
        neg[0] = 1'b1;
        do_step(0, 1, 4'd15, "n1");
        do_step(0, 4, 4'd14, "n2");
        chk("n_dir", dir[0], 1'b0);
        neg[0] = 1'b0;
        tick(3);

        pos[1] = 1'b1;
        neg[1] = 1'b1;
        pulses(1, 10, c);
        chk("both_p1", c, 0);
        neg[1] = 1'b0;
        do_step(1, 1, 4'd1, "a1");
        chk("a1_dir", dir[1], 1'b1);
        pos[1] = 1'b0;
        tick(2);

        tog = 1'b1;
        pos[0] = 1'b1;
        do_step(0, 1, 4'd15, "ce1");
        do_step(0, 8, 4'd0, "ce2");
        do_step(0, 6, 4'd1, "ce3");
        do_step(0, 6, 4'd2, "ce4");
        do_step(0, 4, 4'd3, "ce5");
        tog = 1'b0;
        ce = 1'b1;
        pos[0] = 1'b0;
        tick(2);

        pos[0] = 1'b1;
        do_step(0, 1, 4'd4, "en1");
        do_step(0, 4, 4'd5, "en2");
        enable = 1'b0;
        pulses(0, 10, c);
        chk("dis_p0", c, 0);
        chk("dis_cnt", count[3:0], 4'd5);
        enable = 1'b1;
        do_step(0, 1, 4'd6, "en3");
        do_step(0, 4, 4'd7, "en4");
        tick(2);
        #2 res_n = 1'b0;
        #1 chk("arst_out", {step, dir, qa, qb, count}, 0);
        tick(2);
        res_n = 1'b1;
        do_step(0, 1, 4'd1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
